data_memory: RTL and testbench

- Word-organised data memory for the RV32I single-cycle datapath, fed by the ALU address and rs2 store data.
- Writes are synchronous on the rising edge of clk; reads are combinational.
- Asynchronous active-low reset clears the whole array.

---
 rtl/data_memory.sv | 67 ++++++
 tb/tb_data_memory.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: word-organised RV32I data memory with synchronous writes and combinational reads.
// The optional byte/halfword load-store path is enabled by defining DM_SUBWORD_EN.
// When it is enabled, the module gains the funct3 size-code input.
module data_memory #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
`ifdef DM_SUBWORD_EN
  input  logic [2:0]        funct3,
`endif
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data
);
  localparam int IW = $clog2(DEPTH);
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   word_d;
  logic [31:0]   cur;
  logic [IW-1:0] idx;
  logic          in_range;
  logic          we;
  assign idx      = addr[IW+1:2];
  assign in_range = (addr >> (IW + 2)) == '0;
  assign cur      = mem_q[idx];
`ifdef DM_SUBWORD_EN
  logic        aligned;
  logic [31:0] lane;
  logic [31:0] wrep;
  logic [3:0]  be;
  // size decode, lane extraction, store merge and load extension
  always_comb begin
    aligned   = funct3[1:0] == 2'b00 || (funct3[1:0] == 2'b01 && !addr[0]) ||
                (funct3[1:0] == 2'b10 && addr[1:0] == 2'b00);
    lane      = cur >> {addr[1:0], 3'b000};
    be        = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep      = funct3[1:0] == 2'b00 ? {4{write_data[7:0]}} :
                funct3[1:0] == 2'b01 ? {2{write_data[15:0]}} : write_data;
    word_d    = cur;
    for (int i = 0; i < 4; i++) word_d[8*i+:8] = be[i] ? wrep[8*i+:8] : cur[8*i+:8];
    we        = MemWrite && in_range && aligned && !funct3[2];
    read_data = !(MemRead && in_range && aligned && !(funct3[2] && funct3[1])) ? 32'h0 :
                funct3 == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
                funct3 == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
                funct3 == 3'b100 ? {24'h0, lane[7:0]} :
                funct3 == 3'b101 ? {16'h0, lane[15:0]} : cur;
  end
`else
  logic unused_lsb;
  assign unused_lsb = ^addr[1:0];
  // whole-word access; the byte offset is dropped
  always_comb begin
    word_d    = write_data;
    we        = MemWrite && in_range;
    read_data = (MemRead && in_range) ? cur : 32'h0;
  end
`endif
  // storage: asynchronous clear of every word, otherwise commit the selected write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (we) mem_q[idx] <= word_d;
  end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: table vectors, randomized model comparison and reset/subword sequences for data_memory.
module tb_data_memory;
  localparam int DEPTH = 16;
  localparam int LIM   = DEPTH * 4;
`ifdef DM_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mr = 1'b0, mw = 1'b0;
  logic [2:0]  f3 = 3'b010;
  logic [31:0] a = '0, wd = '0;
  logic [31:0] rd;
  int          errors = 0, checks = 0;
  logic [31:0] model [DEPTH];

  data_memory #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(mr), .MemWrite(mw),
`ifdef DM_SUBWORD_EN
    .funct3(f3),
`endif
    .addr(a), .write_data(wd), .read_data(rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr;
    logic        mw;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] d, input logic [2:0] f);
    @(negedge clk);
    mr = r; mw = w; a = ad; wd = d; f3 = f;
    #1;
  endtask

  function automatic void model_write(input logic w, input logic [31:0] ad, input logic [31:0] d);
    if (w && ad < LIM && (!SUB || ad[1:0] == 2'b00)) model[ad / 4] = d;
  endfunction

  function automatic logic [31:0] model_read(input logic r, input logic [31:0] ad);
    if (!r || ad >= LIM || (SUB && ad[1:0] != 2'b00)) return 32'h0;
    return model[ad / 4];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    logic [31:0] ra, rw;
    logic        rr, rwe;
    clear_model();
    tbl[0]  = '{1'b1, 1'b0, 32'h8,        32'h0,        32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0,        32'hDEADBEEF, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,        32'h0,        32'hDEADBEEF};
    tbl[3]  = '{1'b0, 1'b1, 32'h4,        32'h12345678, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h4,        32'h0,        32'h12345678};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,        32'h0,        32'hDEADBEEF};
    tbl[6]  = '{1'b0, 1'b0, 32'h4,        32'h0,        32'h0};
    tbl[7]  = '{1'b1, 1'b0, LIM,          32'h0,        32'h0};
    tbl[8]  = '{1'b0, 1'b1, LIM,          32'hFFFFFFFF, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,        32'h0,        32'hDEADBEEF};
    tbl[10] = '{1'b1, 1'b1, 32'h4,        32'hAAAA5555, 32'h12345678};
    tbl[11] = '{1'b1, 1'b0, 32'h4,        32'h0,        32'hAAAA5555};
    tbl[12] = '{1'b1, 1'b1, LIM - 2,      32'h0BADF00D, SUB ? 32'h0 : 32'h0};
    tbl[13] = '{1'b1, 1'b0, LIM - 4,      32'h0,        SUB ? 32'h0 : 32'h0BADF00D};
    tbl[14] = '{1'b0, 1'b1, 32'h40000000, 32'h00000001, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 32'h40000000, 32'h0,        32'h0};
    #1;
    chk("reset_hold", rd, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].mr, tbl[i].mw, tbl[i].a, tbl[i].wd, 3'b010);
      chk($sformatf("vec%0d", i), rd, tbl[i].exp);
      model_write(tbl[i].mw, tbl[i].a, tbl[i].wd);
    end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
    chk("mem0_after_oor_write", rd, 32'hDEADBEEF);
    for (int i = 0; i < 400; i++) begin
      rr  = 1'($urandom_range(0, 1));
      rwe = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, LIM + 7));
      if (SUB) ra[1:0] = 2'b00;
      rw  = $urandom;
      drive(rr, rwe, ra, rw, 3'b010);
      chk($sformatf("rand%0d_a%08h", i, ra), rd, model_read(rr, ra));
      model_write(rwe, ra, rw);
    end
    drive(1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 3'b010);
    drive(1'b0, 1'b1, 32'h4, 32'h12345678, 3'b010);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
    chk("pre_async_reset", rd, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_immediate", rd, 32'h0);
    clear_model();
    mw = 1'b1; wd = 32'hCAFEF00D;
    @(posedge clk);
    #1 chk("write_during_reset_rd", rd, 32'h0);
    @(negedge clk);
    mw = 1'b0;
    rst_n = 1'b1;
    #1 chk("post_reset_a0", rd, 32'h0);
    drive(1'b1, 1'b0, 32'h4, 32'h0, 3'b010);
    chk("post_reset_a4", rd, 32'h0);
`ifdef DM_SUBWORD_EN
    drive(1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 3'b010);
    drive(1'b0, 1'b1, 32'h1, 32'h0000007F, 3'b000);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
    chk("sb_then_lw", rd, 32'hDEAD7FEF);
    drive(1'b1, 1'b0, 32'h3, 32'h0, 3'b000);
    chk("lb_a3", rd, 32'hFFFFFFDE);
    drive(1'b1, 1'b0, 32'h3, 32'h0, 3'b100);
    chk("lbu_a3", rd, 32'h000000DE);
    drive(1'b1, 1'b0, 32'h1, 32'h0, 3'b001);
    chk("lh_misaligned", rd, 32'h0);
    drive(1'b0, 1'b1, 32'h2, 32'h00009234, 3'b001);
    drive(1'b1, 1'b0, 32'h2, 32'h0, 3'b001);
    chk("sh_then_lh", rd, 32'hFFFF9234);
    drive(1'b1, 1'b0, 32'h2, 32'h0, 3'b101);
    chk("lhu_a2", rd, 32'h00009234);
    drive(1'b0, 1'b1, 32'h1, 32'hFFFFFFFF, 3'b001);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
    chk("sh_misaligned_ignored", rd, 32'h92347FEF);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 3'b011);
    chk("bad_load_code", rd, 32'h0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
